// File: rtl/card_pkg.sv
// Shared types and constants for the card dealer block.
// The optional baccarat score output is enabled by defining CARD_DEALER_SCORE_EN.
package card_pkg;

    typedef logic [3:0] card_t;

    localparam card_t CARD_NONE = 4'd0;
    localparam card_t CARD_ACE  = 4'd1;
    localparam card_t CARD_KING = 4'd13;
    localparam int    HAND_SIZE = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELIVER = 2'd1,
        FULL    = 2'd2
    } state_e;

    // Baccarat points: aces and pips count face value; ten and court cards count zero.
    function automatic logic [3:0] card_points(input card_t c);
        return ((c >= CARD_ACE) && (c <= 4'd9)) ? c : 4'd0;
    endfunction

    // Reduce a three-card point sum (0..27) modulo 10.
    function automatic logic [3:0] mod10(input logic [4:0] s);
        logic [4:0] r;
        if (s >= 5'd20) begin
            r = s - 5'd20;
        end else if (s >= 5'd10) begin
            r = s - 5'd10;
        end else begin
            r = s;
        end
        return r[3:0];
    endfunction

endpackage

// File: rtl/card_counter.sv
// Free-running 1..13 card value counter; loads START_VALUE on reset and wraps
// from king back to ace. It is the randomness source for the dealer.
module card_counter
    import card_pkg::*;
#(
    parameter int START_VALUE = 1
) (
    input  logic       clock,
    input  logic       resetb,
    output logic [3:0] value
);

    card_t value_q;
    card_t value_d;

    // Next value: wrap king to ace, otherwise increment.
    always_comb begin
        value_d = (value_q == CARD_KING) ? CARD_ACE : value_q + 4'd1;
    end

    // Counter register, asynchronously loaded with the start value.
    // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            value_q <= card_t'(START_VALUE);
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/card_dealer.sv
// Card dealer: deals counter values into a three-slot hand, one card per request,
// with a one-cycle DELIVER gap between deals and a FULL state once the hand is full.
// Define CARD_DEALER_SCORE_EN to add the registered baccarat score output.
module card_dealer
    import card_pkg::*;
#(
    parameter int START_VALUE = 1
) (
    input  logic       clock,
    input  logic       resetb,
    input  logic       deal_req,
    input  logic       hand_clr,
    output logic [3:0] card,
    output logic       card_valid,
    output logic [1:0] card_idx,
    output logic [3:0] hand0,
    output logic [3:0] hand1,
    output logic [3:0] hand2,
    output logic       hand_full
`ifdef CARD_DEALER_SCORE_EN
    ,
    output logic [3:0] score
`endif
);

    card_t  cnt;

    state_e state_q,      state_d;
    logic   [1:0] idx_q,  idx_d;
    card_t  card_q,       card_d;
    logic   card_valid_q, card_valid_d;
    logic   [1:0] card_idx_q, card_idx_d;
    card_t  hand_q [HAND_SIZE];
    card_t  hand_d [HAND_SIZE];
`ifdef CARD_DEALER_SCORE_EN
    logic   [3:0] score_q, score_d;
    logic   [4:0] points_sum;
`endif

    card_counter #(
        .START_VALUE (START_VALUE)
    ) u_counter (
        .clock  (clock),
        .resetb (resetb),
        .value  (cnt)
    );

    // Next-state and datapath: clear wins, IDLE deals, DELIVER waits one cycle.
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        card_d       = card_q;
        card_valid_d = 1'b0;
        card_idx_d   = card_idx_q;
        hand_d       = hand_q;

        if (hand_clr) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            card_d  = CARD_NONE;
            for (int i = 0; i < HAND_SIZE; i++) begin
                hand_d[i] = CARD_NONE;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (deal_req) begin
                        card_d       = cnt;
                        card_idx_d   = idx_q;
                        card_valid_d = 1'b1;
                        idx_d        = idx_q + 2'd1;
                        state_d      = DELIVER;
                        for (int i = 0; i < HAND_SIZE; i++) begin
                            if (idx_q == 2'(i)) begin
                                hand_d[i] = cnt;
                            end
                        end
                    end
                end
                DELIVER: begin
                    state_d = (idx_q == 2'(HAND_SIZE)) ? FULL : IDLE;
                end
                FULL: begin
                    state_d = FULL;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

`ifdef CARD_DEALER_SCORE_EN
        points_sum = 5'(card_points(hand_d[0])) + 5'(card_points(hand_d[1]))
                   + 5'(card_points(hand_d[2]));
        score_d    = mod10(points_sum);
`endif
    end

    // State, hand and output registers; the hand is only three registers, so it is reset.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q      <= IDLE;
            idx_q        <= 2'd0;
            card_q       <= CARD_NONE;
            card_valid_q <= 1'b0;
            card_idx_q   <= 2'd0;
            for (int i = 0; i < HAND_SIZE; i++) begin
                hand_q[i] <= CARD_NONE;
            end
`ifdef CARD_DEALER_SCORE_EN
            score_q      <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            card_q       <= card_d;
            card_valid_q <= card_valid_d;
            card_idx_q   <= card_idx_d;
            hand_q       <= hand_d;
`ifdef CARD_DEALER_SCORE_EN
            score_q      <= score_d;
`endif
        end
    end

    assign card       = card_q;
    assign card_valid = card_valid_q;
    assign card_idx   = card_idx_q;
    assign hand0      = hand_q[0];
    assign hand1      = hand_q[1];
    assign hand2      = hand_q[2];
    assign hand_full  = (state_q == FULL);
`ifdef CARD_DEALER_SCORE_EN
    assign score      = score_q;
`endif

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: directed scenarios with literal expectations,
// then randomized deal/clear traffic, all compared every cycle against a
// queue-based model of the hand. Define CARD_DEALER_SCORE_EN to cover the score.
module tb_card_dealer;

    localparam int START = 1;

    logic       clock;
    logic       resetb;
    logic       deal_req;
    logic       hand_clr;
    logic [3:0] card;
    logic       card_valid;
    logic [1:0] card_idx;
    logic [3:0] hand0;
    logic [3:0] hand1;
    logic [3:0] hand2;
    logic       hand_full;
`ifdef CARD_DEALER_SCORE_EN
    logic [3:0] score;
`endif

    int checks = 0;
    int errors = 0;

    card_dealer #(
        .START_VALUE (START)
    ) dut (
        .clock      (clock),
        .resetb     (resetb),
        .deal_req   (deal_req),
        .hand_clr   (hand_clr),
        .card       (card),
        .card_valid (card_valid),
        .card_idx   (card_idx),
        .hand0      (hand0),
        .hand1      (hand1),
        .hand2      (hand2),
        .hand_full  (hand_full)
`ifdef CARD_DEALER_SCORE_EN
        ,
        .score      (score)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    int m_cnt;          // value the counter presents at the next edge
    int m_hand[$];      // cards held, in deal order
    int m_card;
    int m_valid;        // 1 on the cycle right after a deal
    int m_card_idx;
    int edge_no;

    function automatic int points(input int c);
        return (c >= 1 && c <= 9) ? c : 0;
    endfunction

    function automatic int slot(input int i);
        return (i < m_hand.size()) ? m_hand[i] : 0;
    endfunction

    function automatic int model_score();
        int s = 0;
        for (int i = 0; i < m_hand.size(); i++) s += points(m_hand[i]);
        return s % 10;
    endfunction

    always @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            m_cnt      = START;
            m_hand.delete();
            m_card     = 0;
            m_valid    = 0;
            m_card_idx = 0;
            edge_no    = 0;
        end else begin
            int drawn;
            edge_no++;
            drawn = m_cnt;
            m_cnt = (m_cnt % 13) + 1;
            if (hand_clr) begin
                m_hand.delete();
                m_card  = 0;
                m_valid = 0;
            end else if (m_valid != 0) begin
                // the cycle after a deal never takes another card
                m_valid = 0;
            end else if (deal_req && m_hand.size() < 3) begin
                m_card_idx = m_hand.size();
                m_hand.push_back(drawn);
                m_card     = drawn;
                m_valid    = 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: DUT outputs against the model on every falling edge out of reset.
    always @(negedge clock) begin
        if (resetb) begin
            check("card", card, m_card);
            check("card_valid", card_valid, m_valid);
            if (m_valid != 0) check("card_idx", card_idx, m_card_idx);
            check("hand0", hand0, slot(0));
            check("hand1", hand1, slot(1));
            check("hand2", hand2, slot(2));
            check("hand_full", hand_full, (m_hand.size() == 3 && m_valid == 0) ? 1 : 0);
`ifdef CARD_DEALER_SCORE_EN
            check("score", score, model_score());
`endif
        end
    end

    // ---------------- stimulus ----------------
    // Drive inputs for one rising edge; returns at the following falling edge.
    task automatic tick(input bit dr, input bit hc);
        deal_req = dr;
        hand_clr = hc;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    // Wait for the counter to come round to v, then request it.
    task automatic deal_value(input int v);
        int n = 0;
        tick(1'b0, 1'b0);
        while (m_cnt != v && n < 40) begin
            tick(1'b0, 1'b0);
            n++;
        end
        if (m_cnt != v) check("deal_value_timeout", m_cnt, v);
        tick(1'b1, 1'b0);
        check("deal_value_card", card, v);
        check("deal_value_pulse", card_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetb   = 1'b0;
        deal_req = 1'b0;
        hand_clr = 1'b0;
        repeat (2) @(negedge clock);
        resetb = 1'b1;

        // Reset state
        check("rst_card", card, 0);
        check("rst_valid", card_valid, 0);
        check("rst_idx", card_idx, 0);
        check("rst_hand0", hand0, 0);
        check("rst_full", hand_full, 0);

        // Request sampled at edge 5 deals card 5 into slot 0
        idle(4);
        tick(1'b1, 1'b0);
        check("e5_edge", edge_no, 5);
        check("e5_card", card, 5);
        check("e5_valid", card_valid, 1);
        check("e5_idx", card_idx, 0);
        check("e5_hand0", hand0, 5);
        tick(1'b0, 1'b0);
        check("e6_valid_low", card_valid, 0);

        // Edge 13 deals a king; the edge-14 request lands in DELIVER and is dropped
        idle(6);
        tick(1'b1, 1'b0);
        check("e13_card", card, 13);
        check("e13_idx", card_idx, 1);
        tick(1'b1, 1'b0);
        check("e14_dropped_valid", card_valid, 0);
        check("e14_card_held", card, 13);
        check("e14_hand2", hand2, 0);

        // Edge 27 wraps back to ace in slot 2; hand becomes full after DELIVER
        idle(12);
        tick(1'b1, 1'b0);
        check("e27_edge", edge_no, 27);
        check("e27_card", card, 1);
        check("e27_idx", card_idx, 2);
        check("e27_full_not_yet", hand_full, 0);
        tick(1'b0, 1'b0);
        check("full_set", hand_full, 1);
`ifdef CARD_DEALER_SCORE_EN
        check("score_5_13_1", score, 6);
`endif

        // A fourth request while FULL gives nothing
        tick(1'b1, 1'b0);
        check("full_no_pulse", card_valid, 0);
        check("full_hand0", hand0, 5);
        check("full_hand1", hand1, 13);
        check("full_hand2", hand2, 1);

        // Clear and deal together while FULL: clear wins
        tick(1'b1, 1'b1);
        check("clr_valid", card_valid, 0);
        check("clr_card", card, 0);
        check("clr_hand0", hand0, 0);
        check("clr_hand2", hand2, 0);
        check("clr_full", hand_full, 0);
        tick(1'b1, 1'b0);
        check("clr_next_idx", card_idx, 0);
        check("clr_next_valid", card_valid, 1);

        // Score hands: 7, 8 -> 5; then queen -> 5; fresh 9, 9, 9 -> 7
        tick(1'b0, 1'b1);
        deal_value(7);
        deal_value(8);
`ifdef CARD_DEALER_SCORE_EN
        check("score_7_8", score, 5);
`endif
        deal_value(12);
        tick(1'b0, 1'b0);
        check("q_hand2", hand2, 12);
        check("q_full", hand_full, 1);
`ifdef CARD_DEALER_SCORE_EN
        check("score_7_8_q", score, 5);
`endif
        tick(1'b0, 1'b1);
        deal_value(9);
        deal_value(9);
        deal_value(9);
`ifdef CARD_DEALER_SCORE_EN
        check("score_999", score, 7);
`endif

        // Held-high request deals every second cycle until full
        tick(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0);
            check("held_pulse", card_valid, 1);
            check("held_idx", card_idx, i);
            tick(1'b1, 1'b0);
            check("held_gap", card_valid, 0);
        end
        check("held_full", hand_full, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(99) < 60) ? 1'b1 : 1'b0,
                 ($urandom_range(99) < 8) ? 1'b1 : 1'b0);
        end

        // Reset asserted mid-DELIVER clears outputs without a clock edge
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        check("pre_rst_valid", card_valid, 1);
        deal_req = 1'b0;
        #2;
        resetb = 1'b0;
        #1;
        check("arst_card", card, 0);
        check("arst_valid", card_valid, 0);
        check("arst_idx", card_idx, 0);
        check("arst_hand0", hand0, 0);
        check("arst_hand1", hand1, 0);
        check("arst_hand2", hand2, 0);
        check("arst_full", hand_full, 0);
`ifdef CARD_DEALER_SCORE_EN
        check("arst_score", score, 0);
`endif
        @(negedge clock);
        resetb = 1'b1;
        // First edge after release samples the request and draws START_VALUE
        tick(1'b1, 1'b0);
        check("post_rst_card", card, START);
        check("post_rst_valid", card_valid, 1);
        check("post_rst_idx", card_idx, 0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 SHALL have parameter: START_VALUE, default 1, counter value loaded at reset (legal 1..13).
REQ-002 SHALL have port: clock  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: resetb  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: deal_req  input  1  request one card, level sampled each rising edge.
REQ-005 SHALL have port: hand_clr  input  1  clear the hand, sampled each rising edge.
REQ-006 SHALL have port: card  output  4  last dealt card code: 0 none, 1 ace, 2..10 pips, 11 J, 12 Q, 13 K (the code the 7-segment card display decodes).
REQ-007 SHALL have port: card_valid  output  1  one-cycle pulse marking a newly dealt card.
REQ-008 SHALL have port: card_idx  output  2  hand slot (0..2) of the dealt card, valid with card_valid.
REQ-009 SHALL have ports: hand0, hand1, hand2  output  4 each  held card per slot, 0 if empty.
REQ-010 SHALL have port: hand_full  output  1  high while all three slots are filled.
REQ-011 SHALL have port (CARD_DEALER_SCORE_EN only): score  output  4  baccarat hand score 0..9.

Function
REQ-012 SHALL run a free counter cnt: each edge cnt <= (cnt == 13) ? 1 : cnt+1; never 0 or 14..15; unaffected by hand_clr.
REQ-013 SHALL implement FSM states IDLE, DELIVER, FULL.
REQ-014 IDLE with deal_req=1 and hand_clr=0 at an edge SHALL, at that same edge: write the pre-edge cnt into card and slot hand[idx]; set card_idx=idx; set card_valid=1; advance idx; go to DELIVER.
REQ-015 DELIVER SHALL last exactly one cycle, with deal_req ignored; it SHALL exit to FULL if three slots are filled, else to IDLE; card_valid SHALL be 0 after the exit.
REQ-016 FULL SHALL ignore deal_req: no pulse, hand unchanged; hand_full=1 in FULL only.
REQ-017 hand_clr=1 at any edge SHALL: zero hand0..2 and card; set idx=0; set card_valid=0; go to IDLE. It SHALL win over a simultaneous deal_req, and no card is dealt.
REQ-018 Latency: request sampled at edge N -> card/card_valid visible after edge N; minimum request spacing 2 cycles.
REQ-019 A held-high deal_req SHALL deal every second cycle until FULL.

Reset
REQ-020 resetb low SHALL immediately force: cnt=START_VALUE; state IDLE; idx=0; card=0; card_valid=0; card_idx=0; hand0..2=0; hand_full=0; score=0. This SHALL apply mid-DELIVER too.
REQ-021 After resetb rises, the first edge SHALL sample deal_req normally.

Configuration
REQ-022 Macro CARD_DEALER_SCORE_EN defined: score SHALL equal (sum of per-card points) mod 10. Points: 1..9 = face value; 0 for empty, 10, J, Q, K. score SHALL update in the same edge as the slot write.
REQ-023 Macro undefined: the score port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-024 Package card_pkg SHALL hold: typedef card_t (4-bit); constants CARD_NONE=0, CARD_ACE=1, CARD_KING=13, HAND_SIZE=3; the FSM state enum.
REQ-025 The 1..13 wrap counter SHALL be the sub-module card_counter (clock, resetb, value); the FSM, hand storage and score stay in card_dealer.

Verification
REQ-026 Reset with START_VALUE=1, then deal_req sampled at edge 5 -> card=5, card_valid=1 for one cycle, card_idx=0, hand0=5.
REQ-027 deal_req sampled at edge 13, then again at edge 14 -> card=13; the edge-14 request is dropped (DELIVER). A request sampled at edge 27 -> card=1 (wrap check).
REQ-028 Three spaced requests -> card_idx 0,1,2; hand_full=1 after the third; a fourth request gives no pulse and no slot change.
REQ-029 hand_clr and deal_req high at the same edge while FULL -> all slots 0, idx 0, card_valid=0, state IDLE.
REQ-030 With CARD_DEALER_SCORE_EN: cards 7, 8 -> score=5; then 12 -> score=5; fresh hand 9, 9, 9 -> score=7.
REQ-031 resetb pulsed low mid-DELIVER -> outputs zero at once, no clock required; cnt=START_VALUE.
